uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
// Upstream feeder for the 32-bit LED/scratch CPU: receives a program image over UART (8N1),
// assembles big-endian 32-bit words and writes them into the CPU's instruction RAM. Holds
// the CPU stalled while loading, then releases it with a restart pulse (CPU reloads pc=0).
// PARAMETERS
// CLK_HZ       16000000  input clock frequency
// BAUD         115200    UART bit rate; bit period = CLK_HZ/BAUD cycles, rounded down
// ADDR_W       11        instruction RAM address width
// MAX_WORDS    2048      largest accepted image length, in words
// TIMEOUT_CYC  1600000   inter-byte timeout (100 ms @16 MHz), counted in non-IDLE states
// PORTS
// CLK          in   1       16 MHz system clock
// RST_N        in   1       asynchronous, active-low reset
// UART_RX      in   1       serial input, idle high; passed through a 2-FF synchroniser
// wr_en        out  1       RAM write strobe, one cycle per word
// wr_addr      out  ADDR_W  word address, 0..count-1
// wr_data      out  32      assembled word; first byte received is bits [31:24]
// cpu_hold     out  1       1 = CPU must not fetch or execute
// cpu_restart  out  1       one-cycle pulse: CPU sets pc<=0, instr_phase<=0
// load_done    out  1       one-cycle pulse: image accepted
// load_err     out  1       sticky; set on any failure, cleared on next sync byte
// BEHAVIOUR
// - Reset: all outputs 0. FSM=IDLE, counters cleared. The CPU runs its power-up image.
// - Frame: 0xA5 sync, LEN_HI, LEN_LO (word count N), 4*N data bytes, CSUM.
//   CSUM = 8-bit mod-256 sum of the LEN_HI, LEN_LO and data bytes.
// - FSM: IDLE -> LEN_HI -> LEN_LO -> DATA -> CSUM -> IDLE.
//   IDLE: non-0xA5 bytes are discarded. On 0xA5: cpu_hold<=1, load_err<=0, sum<=0.
//   LEN_LO: if N==0, go to CSUM. If N>MAX_WORDS, fail.
//   DATA: shift the byte into wr_data. On the 4th byte, assert wr_en for exactly one cycle
//     with the current wr_addr; wr_addr increments in the following cycle. Go to CSUM
//     after word N-1.
//   CSUM: on match, cpu_restart=1 and load_done=1 in the same cycle, and cpu_hold<=0 in
//     that cycle (low from the next cycle). On mismatch, fail.
// - Fail: load_err<=1, FSM->IDLE. cpu_hold stays 1: a partial or corrupt image never runs.
//   Only a later successful frame releases cpu_hold.
// - Timeout: counter resets on every received byte. When it reaches TIMEOUT_CYC in a
//   non-IDLE state, fail. A 0xA5 byte received outside IDLE is ordinary data, not a resync.
// - RX sampling: a start bit is detected on a falling edge and re-checked at the half-bit
//   point; a low there is a valid start, a high is a glitch (return to idle, no byte).
//   Data bits are sampled mid-bit, LSB first. If the stop bit is 0 (framing error), the
//   byte is dropped and the loader fails if not in IDLE.
// - Byte->write latency: wr_en is asserted 1 cycle after the rx_valid of the 4th byte.
// - Asynchronous reset mid-load clears everything, cpu_hold included; the RAM keeps any
//   words already written.
// STRUCTURE
// - Shared header loader_defs.vh holds LOADER_SYNC=8'hA5 and the FSM state encodings
//   (3 bits: IDLE, LEN_HI, LEN_LO, DATA, CSUM).
// - Sub-module uart_rx (CLK, RST_N, rx, rx_data[7:0], rx_valid, rx_ferr): synchroniser,
//   baud counter and bit shifter. The loader FSM, checksum, word assembly and timeout sit
//   in the top module. A top-level mux gives the loader priority over the CPU RAM port
//   when wr_en=1.
// TESTING
// - Frame A5 00 02 20000001 10200000 + csum -> wr_en x2: addr0=20000001, addr1=10200000;
//   load_done, cpu_restart, cpu_hold 1->0; load_err=0.
// - Same frame with csum+1 -> both writes occur, load_err=1, cpu_hold stays 1,
//   no cpu_restart.
// - A5 08 01 (N=2049 > MAX_WORDS) -> load_err=1, no wr_en, FSM back in IDLE.
// - A5 00 00 00 (N=0, csum 0) -> load_done with zero writes; cpu_hold released.
// - A5 00 01 + 2 data bytes, then silence for TIMEOUT_CYC+10 cycles -> load_err=1,
//   cpu_hold=1. Then send a good frame -> load_err=0, cpu_hold=0.
// - Bytes 00 FF 5A before A5 -> ignored. RST_N pulsed low mid-DATA -> all outputs 0
//   immediately.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: sync byte, FSM encodings
// and the running checksum helper.
package uart_prog_loader_pkg;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  // Loader frame FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4
  } loader_state_e;

  // UART receiver bit-level states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Mod-256 running sum over length and data bytes
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/uart_prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, start-bit glitch
// rejection and stop-bit framing check. Emits one-cycle rx_valid / rx_ferr.
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 16000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int unsigned BIT_CYC  = CLK_HZ / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int          CNT_W    = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_e        st_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;

  // Bring the asynchronous line into the clock domain; keep one extra stage for edge detect
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Bit-timing FSM: find start edge, confirm at half bit, sample data and stop mid-bit
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q     <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (st_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (prev_q && !sync2_q) st_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= '0;
            // A high line here means the falling edge was only a glitch
            st_q  <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) st_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            st_q  <= RX_IDLE;
            if (sync2_q) begin
              rx_data  <= shift_q;
              rx_valid <= 1'b1;
            end else begin
              rx_ferr  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: st_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: parses A5/LEN/DATA/CSUM frames, writes big-endian
// words into instruction RAM, holds the CPU while loading and releases it
// with a restart pulse only after a checksum-verified image.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 16000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned MAX_WORDS   = 2048,
  parameter int unsigned TIMEOUT_CYC = 1600000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              UART_RX,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              load_done,
  output logic              load_err
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]    MAX_N    = 16'(MAX_WORDS);

  logic [7:0]        rx_data;
  logic              rx_valid, rx_ferr;

  loader_state_e     st_q;
  logic [15:0]       len_q;
  logic [7:0]        sum_q;
  logic [1:0]        byte_cnt_q;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              tmo_hit;
  logic [15:0]       len_full;
  logic              last_word;

  logic              wr_en_q, hold_q, restart_q, done_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .rx       (UART_RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  assign len_full  = {len_q[15:8], rx_data};
  assign last_word = (16'(wr_addr_q) == len_q - 16'd1);

  // Inter-byte timeout: cleared by any received byte, idle while waiting for sync
  always_comb begin
    tmo_d   = tmo_q + 1'b1;
    tmo_hit = 1'b0;
    if (st_q == ST_IDLE || rx_valid || rx_ferr) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_hit = 1'b1;
    end
  end

  // Frame FSM with word assembly, checksum and registered control outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q       <= ST_IDLE;
      len_q      <= '0;
      sum_q      <= '0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hold_q     <= 1'b0;
      restart_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      restart_q <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= tmo_d;
      // Address advances the cycle after its write strobe
      if (wr_en_q) wr_addr_q <= wr_addr_q + 1'b1;

      if ((rx_ferr && st_q != ST_IDLE) || tmo_hit) begin
        // cpu_hold deliberately stays set: a partial image must never run
        err_q <= 1'b1;
        st_q  <= ST_IDLE;
      end else if (rx_valid) begin
        case (st_q)
          ST_IDLE: begin
            if (rx_data == LOADER_SYNC) begin
              hold_q     <= 1'b1;
              err_q      <= 1'b0;
              sum_q      <= '0;
              wr_addr_q  <= '0;
              byte_cnt_q <= '0;
              st_q       <= ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            len_q[15:8] <= rx_data;
            sum_q       <= csum_add(sum_q, rx_data);
            st_q        <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            len_q <= len_full;
            sum_q <= csum_add(sum_q, rx_data);
            if (len_full == 16'd0) begin
              st_q <= ST_CSUM;
            end else if (len_full > MAX_N) begin
              err_q <= 1'b1;
              st_q  <= ST_IDLE;
            end else begin
              st_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            wr_data_q  <= {wr_data_q[23:0], rx_data};
            sum_q      <= csum_add(sum_q, rx_data);
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wr_en_q <= 1'b1;
              if (last_word) st_q <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            st_q <= ST_IDLE;
            if (rx_data == sum_q) begin
              restart_q <= 1'b1;
              done_q    <= 1'b1;
              hold_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: st_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cpu_hold    = hold_q;
  assign cpu_restart = restart_q;
  assign load_done   = done_q;
  assign load_err    = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: frames are described as word lists,
// expected writes and outcomes are queued, and a monitor checks DUT activity.
module tb_uart_prog_loader;

  localparam int unsigned CLK_HZ  = 16000000;
  localparam int unsigned BAUD    = 2000000;
  localparam int          BIT     = 8;
  localparam int unsigned TMO     = 400;
  localparam int          MAXW    = 2048;
  localparam int          EV_DONE = 1;
  localparam int          EV_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold, cpu_restart, load_done, load_err;

  typedef struct {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  int          exp_ev[$];
  logic [31:0] words_a[0:15];
  bit          hold_m, err_m;
  int          checks = 0;
  int          errors = 0;

  uart_prog_loader #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .ADDR_W      (11),
    .MAX_WORDS   (MAXW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .UART_RX     (uart_rx),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cpu_hold    (cpu_hold),
    .cpu_restart (cpu_restart),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop expectations whenever the DUT writes or signals an outcome
  initial begin
    bit err_prev;
    wr_t e;
    int ev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        err_prev = 1'b0;
      end else begin
        if (wr_en) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", {wr_addr, wr_data}, 64'd0);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
          end
        end
        if (load_done || cpu_restart) begin
          chk("restart_with_done", cpu_restart, load_done);
          ev = (exp_ev.size() == 0) ? 0 : exp_ev.pop_front();
          chk("outcome_done", EV_DONE, ev);
        end
        if (load_err && !err_prev) begin
          ev = (exp_ev.size() == 0) ? 0 : exp_ev.pop_front();
          chk("outcome_err", EV_ERR, ev);
        end
        err_prev = load_err;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(posedge clk);
    end
    uart_rx = stop_ok;
    repeat (BIT) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (exp_wr.size() == 0 && exp_ev.size() == 0) break;
      @(negedge clk);
    end
    chk({name, "_pending"}, 64'(exp_wr.size() + exp_ev.size()), 64'd0);
    exp_wr.delete();
    exp_ev.delete();
  endtask

  task automatic check_levels(input string name);
    @(negedge clk);
    chk({name, "_hold"}, cpu_hold, hold_m);
    chk({name, "_err"}, load_err, err_m);
  endtask

  // Reference behaviour of a whole frame: writes for every word when the length
  // is legal, then success iff the checksum byte is correct.
  task automatic send_frame(input string name, input int n, input bit bad_csum, input bit glitch);
    int          total;
    logic [15:0] n16;
    logic [7:0]  b;
    n16   = n[15:0];
    total = int'(n16[15:8]) + int'(n16[7:0]);
    if (n > MAXW) begin
      exp_ev.push_back(EV_ERR);
      hold_m = 1'b1;
      err_m  = 1'b1;
      send_byte(8'hA5, 1'b1);
      send_byte(n16[15:8], 1'b1);
      send_byte(n16[7:0], 1'b1);
    end else begin
      for (int w = 0; w < n; w++) begin
        exp_wr.push_back('{addr: w[10:0], data: words_a[w]});
        for (int k = 0; k < 4; k++) total += int'(words_a[w][31-8*k -: 8]);
      end
      exp_ev.push_back(bad_csum ? EV_ERR : EV_DONE);
      hold_m = bad_csum;
      err_m  = bad_csum;
      send_byte(8'hA5, 1'b1);
      send_byte(n16[15:8], 1'b1);
      send_byte(n16[7:0], 1'b1);
      for (int w = 0; w < n; w++) begin
        for (int k = 0; k < 4; k++) begin
          send_byte(words_a[w][31-8*k -: 8], 1'b1);
          if (glitch && w == 0 && k == 0) begin
            uart_rx = 1'b0;
            repeat (2) @(posedge clk);
            uart_rx = 1'b1;
            repeat (2 * BIT) @(posedge clk);
          end
        end
      end
      b = 8'(total % 256) + {7'd0, bad_csum};
      send_byte(b, 1'b1);
    end
    wait_drain(name);
    check_levels(name);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hold_m = 1'b0;
    err_m  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {wr_en, wr_addr, wr_data, cpu_hold, cpu_restart, load_done, load_err}, 64'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Noise before sync is discarded
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    check_levels("noise");

    // Good two-word image
    words_a[0] = 32'h20000001;
    words_a[1] = 32'h10200000;
    send_frame("good2", 2, 1'b0, 1'b0);

    // Same image, corrupted checksum
    send_frame("badcsum", 2, 1'b1, 1'b0);

    // Oversized length
    send_frame("toolong", 2049, 1'b0, 1'b0);

    // Empty image
    send_frame("empty", 0, 1'b0, 1'b0);

    // Truncated frame then silence -> timeout
    words_a[0] = 32'hDEADBEEF;
    exp_ev.push_back(EV_ERR);
    hold_m = 1'b1;
    err_m  = 1'b1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    repeat (TMO + 10) @(posedge clk);
    wait_drain("timeout");
    check_levels("timeout");

    words_a[0] = 32'h00A5A5FF;
    words_a[1] = 32'h12345678;
    send_frame("recover", 2, 1'b0, 1'b0);

    // Framing error on a data byte
    exp_ev.push_back(EV_ERR);
    hold_m = 1'b1;
    err_m  = 1'b1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h3C, 1'b0);
    wait_drain("ferr");
    check_levels("ferr");

    // Start-bit glitch inside a frame must not inject a byte
    words_a[0] = 32'hCAFEF00D;
    words_a[1] = 32'h0BADC0DE;
    send_frame("glitch", 2, 1'b0, 1'b1);

    // Randomised frames with random leading noise
    for (int f = 0; f < 4; f++) begin
      int n;
      int g;
      logic [7:0] nb;
      g = int'($urandom_range(0, 2));
      for (int j = 0; j < g; j++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb, 1'b1);
      end
      n = int'($urandom_range(1, 5));
      for (int w = 0; w < n; w++) words_a[w] = $urandom;
      send_frame("rand", n, ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of DATA
    words_a[0] = 32'h11223344;
    exp_wr.push_back('{addr: 11'd0, data: 32'h11223344});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    hold_m = 1'b1;
    err_m  = 1'b0;
    check_levels("mid_data");
    chk("mid_data_writes_left", 64'(exp_wr.size()), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("reset_mid", {wr_en, wr_addr, wr_data, cpu_hold, cpu_restart, load_done, load_err}, 64'd0);
    hold_m = 1'b0;
    err_m  = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    words_a[0] = 32'h0F0F0F0F;
    send_frame("after_reset", 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
